// File: rtl/matrix_stream_serializer_pkg.sv
// Shared definitions for the flat-matrix stream blocks: element width,
// index-width helper and the serializer FSM state type.
`ifndef MATRIX_DEFS_VH
`define MATRIX_DEFS_VH
`define FLOAT_W 32
`define MATRIX_IDX_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package matrix_stream_serializer_pkg;

    localparam int FLOAT_W = `FLOAT_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    // Index width is never zero so a 1-wide dimension still gets a real port.
    function automatic int idx_w(input int n);
        return `MATRIX_IDX_W(n);
    endfunction

endpackage

// File: rtl/matrix_stream_serializer_if.sv
// Capture handshake (flat matrix in) and element stream (one float32 out)
// of the matrix serializer.
interface matrix_stream_serializer_if
    import matrix_stream_serializer_pkg::*;
#(
    parameter int ROWS = 1,
    parameter int COLS = 1
);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);

    logic                         in_valid;
    logic                         in_ready;
    logic [FLOAT_W*ROWS*COLS-1:0] in_matrix;
    logic                         out_valid;
    logic                         out_ready;
    logic [FLOAT_W-1:0]           out_data;
    logic [RW-1:0]                out_row;
    logic [CW-1:0]                out_col;
    logic                         out_last;

    modport master (
        output in_valid, in_matrix, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last
    );

    modport slave (
        input  in_valid, in_matrix, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last
    );

endinterface

// File: rtl/matrix_stream_serializer_counter.sv
// Two-level wrapping index counter; the inner index runs fastest and the
// outer index steps each time the inner one wraps.
module matrix_index_counter
    import matrix_stream_serializer_pkg::*;
#(
    parameter int INNER_MAX = 0,
    parameter int OUTER_MAX = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            advance,
    output logic [idx_w(INNER_MAX + 1)-1:0] inner,
    output logic [idx_w(OUTER_MAX + 1)-1:0] outer,
    output logic                            at_end
);
    localparam int IW = idx_w(INNER_MAX + 1);
    localparam int OW = idx_w(OUTER_MAX + 1);
    localparam logic [IW-1:0] INNER_LAST = IW'(INNER_MAX);
    localparam logic [OW-1:0] OUTER_LAST = OW'(OUTER_MAX);

    logic [IW-1:0] r_inner;
    logic [OW-1:0] r_outer;
    logic          w_inner_wrap;
    logic          w_outer_wrap;

    assign w_inner_wrap = (r_inner == INNER_LAST);
    assign w_outer_wrap = (r_outer == OUTER_LAST);

    // Clear has priority so a new matrix captured on the final advance restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inner <= '0;
            r_outer <= '0;
        end else if (clear) begin
            r_inner <= '0;
            r_outer <= '0;
        end else if (advance) begin
            if (w_inner_wrap) begin
                r_inner <= '0;
                r_outer <= w_outer_wrap ? '0 : r_outer + OW'(1);
            end else begin
                r_inner <= r_inner + IW'(1);
            end
        end
    end

    assign inner  = r_inner;
    assign outer  = r_outer;
    assign at_end = w_inner_wrap && w_outer_wrap;

endmodule

// File: rtl/matrix_stream_serializer.sv
// Captures a flat row-major float32 matrix in one handshake and streams its
// elements out one per cycle, in row-major or column-major order.
module matrix_stream_serializer
    import matrix_stream_serializer_pkg::*;
#(
    parameter int ROWS      = 1,
    parameter int COLS      = 1,
    parameter int COL_MAJOR = 0
) (
    input logic                    clk,
    input logic                    rst_n,
    matrix_stream_serializer_if.slave bus
);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam int MW = FLOAT_W * ROWS * COLS;
    localparam int LW = idx_w(MW);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [MW-1:0]      r_matrix;
    logic [RW-1:0]      w_row;
    logic [CW-1:0]      w_col;
    logic [LW-1:0]      w_lsb;
    logic               w_at_end;
    logic               w_out_valid;
    logic               w_out_hs;
    logic               w_out_last;
    logic               w_in_ready;
    logic               w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new capture on the last handshake keeps us in SEND for bubble-free back-to-back matrices.
    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && w_at_end && !bus.in_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_out_hs   = w_out_valid && bus.out_ready;
    assign w_out_last = w_out_valid && w_at_end;
    assign w_in_ready = (r_state == S_IDLE) || (w_out_hs && w_out_last);
    assign w_capture  = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_matrix <= '0;
        end else if (w_capture) begin
            r_matrix <= bus.in_matrix;
        end
    end

    if (COL_MAJOR != 0) begin : g_col_major
        matrix_index_counter #(
            .INNER_MAX (ROWS - 1),
            .OUTER_MAX (COLS - 1)
        ) u_index (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (w_capture),
            .advance (w_out_hs),
            .inner   (w_row),
            .outer   (w_col),
            .at_end  (w_at_end)
        );
    end else begin : g_row_major
        matrix_index_counter #(
            .INNER_MAX (COLS - 1),
            .OUTER_MAX (ROWS - 1)
        ) u_index (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (w_capture),
            .advance (w_out_hs),
            .inner   (w_col),
            .outer   (w_row),
            .at_end  (w_at_end)
        );
    end

    // Bit offset of element (row,col); the index width exactly spans the captured register.
    assign w_lsb = LW'(FLOAT_W) * (LW'(COLS) * LW'(w_row) + LW'(w_col));

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_matrix[w_lsb +: FLOAT_W];
    assign bus.out_row   = w_row;
    assign bus.out_col   = w_col;
    assign bus.out_last  = w_out_last;

endmodule

// File: tb/tb_matrix_stream_serializer.sv
// Directed bench for matrix_stream_serializer: one DUT per geometry/order,
// hand-computed element sequences, one task per scenario.
module tb_matrix_stream_serializer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    matrix_stream_serializer_if #(.ROWS(2), .COLS(3)) if_rm  ();
    matrix_stream_serializer_if #(.ROWS(2), .COLS(3)) if_cm  ();
    matrix_stream_serializer_if #(.ROWS(2), .COLS(2)) if_bb  ();
    matrix_stream_serializer_if #(.ROWS(3), .COLS(3)) if_rs  ();
    matrix_stream_serializer_if #(.ROWS(1), .COLS(1)) if_one ();

    matrix_stream_serializer #(.ROWS(2), .COLS(3), .COL_MAJOR(0)) u_rm  (.clk(clk), .rst_n(rst_n), .bus(if_rm));
    matrix_stream_serializer #(.ROWS(2), .COLS(3), .COL_MAJOR(1)) u_cm  (.clk(clk), .rst_n(rst_n), .bus(if_cm));
    matrix_stream_serializer #(.ROWS(2), .COLS(2), .COL_MAJOR(0)) u_bb  (.clk(clk), .rst_n(rst_n), .bus(if_bb));
    matrix_stream_serializer #(.ROWS(3), .COLS(3), .COL_MAJOR(0)) u_rs  (.clk(clk), .rst_n(rst_n), .bus(if_rs));
    matrix_stream_serializer #(.ROWS(1), .COLS(1), .COL_MAJOR(0)) u_one (.clk(clk), .rst_n(rst_n), .bus(if_one));

    // 2x3 matrix [[1,2,3],[4,5,6]], element (r,c) at word 3*r+c
    localparam logic [191:0] M23 = {32'h40C00000, 32'h40A00000, 32'h40800000,
                                    32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] MA = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    localparam logic [127:0] MB = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
    localparam logic [287:0] MC = {32'hC0000008, 32'hC0000007, 32'hC0000006, 32'hC0000005, 32'hC0000004,
                                   32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
    localparam logic [287:0] MD = {32'hD0000008, 32'hD0000007, 32'hD0000006, 32'hD0000005, 32'hD0000004,
                                   32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};

    logic [31:0] rm_data [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                 32'h40800000, 32'h40A00000, 32'h40C00000};
    int          rm_row  [6] = '{0, 0, 0, 1, 1, 1};
    int          rm_col  [6] = '{0, 1, 2, 0, 1, 2};
    logic [31:0] cm_data [6] = '{32'h3F800000, 32'h40800000, 32'h40000000,
                                 32'h40A00000, 32'h40400000, 32'h40C00000};
    int          cm_row  [6] = '{0, 1, 0, 1, 0, 1};
    int          cm_col  [6] = '{0, 0, 1, 1, 2, 2};

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (if_rm.out_valid !== 1'b0 || if_rm.out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: valid=%b last=%b, want 0 0", if_rm.out_valid, if_rm.out_last);
        end
        n_vec++;
        if (if_rm.out_data !== 32'h0 || if_rm.out_row !== 1'b0 || if_rm.out_col !== 2'b00) begin
            n_err++;
            $display("FAIL reset_data: data=%h row=%0d col=%0d, want 0 0 0", if_rm.out_data, if_rm.out_row, if_rm.out_col);
        end
        n_vec++;
        if (if_rm.in_ready !== 1'b1 || if_one.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: rm=%b one=%b, want 1 1", if_rm.in_ready, if_one.in_ready);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (if_cm.out_valid !== 1'b0 || if_cm.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_idle: valid=%b in_ready=%b, want 0 1", if_cm.out_valid, if_cm.in_ready);
        end
    endtask

    task automatic test_row_major();
        if_rm.out_ready = 1'b1;
        if_rm.in_valid  = 1'b1;
        if_rm.in_matrix = M23;
        #1;
        n_vec++;
        if (if_rm.in_ready !== 1'b1 || if_rm.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rm_capture: in_ready=%b valid=%b, want 1 0", if_rm.in_ready, if_rm.out_valid);
        end
        @(posedge clk);
        #1;
        if_rm.in_valid  = 1'b0;
        if_rm.in_matrix = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_vec++;
            if (if_rm.out_valid !== 1'b1 || if_rm.out_data !== rm_data[k]) begin
                n_err++;
                $display("FAIL rm_data[%0d]: valid=%b data=%h, want 1 %h", k, if_rm.out_valid, if_rm.out_data, rm_data[k]);
            end
            n_vec++;
            if (int'(if_rm.out_row) != rm_row[k] || int'(if_rm.out_col) != rm_col[k]) begin
                n_err++;
                $display("FAIL rm_pos[%0d]: (%0d,%0d), want (%0d,%0d)", k, if_rm.out_row, if_rm.out_col, rm_row[k], rm_col[k]);
            end
            n_vec++;
            if (if_rm.out_last !== (k == 5) || if_rm.in_ready !== (k == 5)) begin
                n_err++;
                $display("FAIL rm_last[%0d]: last=%b in_ready=%b, want %b", k, if_rm.out_last, if_rm.in_ready, (k == 5));
            end
            @(posedge clk);
            #1;
        end
        #1;
        n_vec++;
        if (if_rm.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rm_drained: valid=%b, want 0", if_rm.out_valid);
        end
    endtask

    task automatic test_col_major();
        if_cm.out_ready = 1'b1;
        if_cm.in_valid  = 1'b1;
        if_cm.in_matrix = M23;
        @(posedge clk);
        #1;
        if_cm.in_valid  = 1'b0;
        if_cm.in_matrix = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_vec++;
            if (if_cm.out_valid !== 1'b1 || if_cm.out_data !== cm_data[k]) begin
                n_err++;
                $display("FAIL cm_data[%0d]: valid=%b data=%h, want 1 %h", k, if_cm.out_valid, if_cm.out_data, cm_data[k]);
            end
            n_vec++;
            if (int'(if_cm.out_row) != cm_row[k] || int'(if_cm.out_col) != cm_col[k]) begin
                n_err++;
                $display("FAIL cm_pos[%0d]: (%0d,%0d), want (%0d,%0d)", k, if_cm.out_row, if_cm.out_col, cm_row[k], cm_col[k]);
            end
            n_vec++;
            if (if_cm.out_last !== (k == 5)) begin
                n_err++;
                $display("FAIL cm_last[%0d]: last=%b, want %b", k, if_cm.out_last, (k == 5));
            end
            @(posedge clk);
            #1;
        end
        #1;
        n_vec++;
        if (if_cm.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cm_drained: valid=%b, want 0", if_cm.out_valid);
        end
    endtask

    task automatic test_backpressure();
        int k   = 0;
        int cyc = 0;
        if_rm.out_ready = 1'b0;
        if_rm.in_valid  = 1'b1;
        if_rm.in_matrix = M23;
        @(posedge clk);
        #1;
        if_rm.in_valid  = 1'b0;
        if_rm.in_matrix = {6{32'hDEADBEEF}};
        while (k < 6 && cyc < 40) begin
            if_rm.out_ready = (cyc % 3 == 0);
            #1;
            n_vec++;
            if (if_rm.out_valid !== 1'b1 || if_rm.out_data !== rm_data[k]) begin
                n_err++;
                $display("FAIL bp_data[c%0d]: valid=%b data=%h, want 1 %h", cyc, if_rm.out_valid, if_rm.out_data, rm_data[k]);
            end
            n_vec++;
            if (int'(if_rm.out_row) != rm_row[k] || int'(if_rm.out_col) != rm_col[k] || if_rm.out_last !== (k == 5)) begin
                n_err++;
                $display("FAIL bp_pos[c%0d]: (%0d,%0d) last=%b, want (%0d,%0d) %b", cyc, if_rm.out_row, if_rm.out_col,
                         if_rm.out_last, rm_row[k], rm_col[k], (k == 5));
            end
            n_vec++;
            if (if_rm.in_ready !== (if_rm.out_ready && k == 5)) begin
                n_err++;
                $display("FAIL bp_in_ready[c%0d]: got %b, want %b", cyc, if_rm.in_ready, (if_rm.out_ready && k == 5));
            end
            if (if_rm.out_ready) k++;
            cyc++;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (k != 6) begin
            n_err++;
            $display("FAIL bp_timeout: %0d elements, want 6", k);
        end
        if_rm.out_ready = 1'b1;
        #1;
        n_vec++;
        if (if_rm.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drained: valid=%b, want 0", if_rm.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        if_bb.out_ready = 1'b1;
        if_bb.in_valid  = 1'b1;
        if_bb.in_matrix = MA;
        #1;
        n_vec++;
        if (if_bb.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bb_capture: in_ready=%b, want 1", if_bb.in_ready);
        end
        @(posedge clk);
        #1;
        for (int j = 1; j <= 8; j++) begin
            if_bb.in_valid  = (j == 4);
            if_bb.in_matrix = (j == 4) ? MB : '0;
            #1;
            exp = ((j <= 4) ? 32'hA0000000 : 32'hB0000000) + 32'((j - 1) % 4);
            n_vec++;
            if (if_bb.out_valid !== 1'b1 || if_bb.out_data !== exp) begin
                n_err++;
                $display("FAIL bb_data[%0d]: valid=%b data=%h, want 1 %h", j, if_bb.out_valid, if_bb.out_data, exp);
            end
            n_vec++;
            if (int'(if_bb.out_row) != ((j - 1) % 4) / 2 || int'(if_bb.out_col) != (j - 1) % 2) begin
                n_err++;
                $display("FAIL bb_pos[%0d]: (%0d,%0d), want (%0d,%0d)", j, if_bb.out_row, if_bb.out_col, ((j - 1) % 4) / 2, (j - 1) % 2);
            end
            n_vec++;
            if (if_bb.out_last !== (j == 4 || j == 8)) begin
                n_err++;
                $display("FAIL bb_last[%0d]: got %b, want %b", j, if_bb.out_last, (j == 4 || j == 8));
            end
            if (j < 8) begin
                n_vec++;
                if (if_bb.in_ready !== (j == 4)) begin
                    n_err++;
                    $display("FAIL bb_in_ready[%0d]: got %b, want %b", j, if_bb.in_ready, (j == 4));
                end
            end
            @(posedge clk);
            #1;
        end
        if_bb.in_valid = 1'b0;
        #1;
        n_vec++;
        if (if_bb.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bb_drained: valid=%b, want 0", if_bb.out_valid);
        end
    endtask

    task automatic test_reset_mid_send();
        if_rs.out_ready = 1'b1;
        if_rs.in_valid  = 1'b1;
        if_rs.in_matrix = MC;
        @(posedge clk);
        #1;
        if_rs.in_valid  = 1'b0;
        if_rs.in_matrix = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (if_rs.out_data !== 32'hC0000000 + 32'(k)) begin
                n_err++;
                $display("FAIL rs_pre[%0d]: data=%h, want %h", k, if_rs.out_data, 32'hC0000000 + 32'(k));
            end
            @(posedge clk);
            #1;
        end
        #1;
        n_vec++;
        if (if_rs.out_data !== 32'hC0000003 || if_rs.out_row !== 2'd1 || if_rs.out_col !== 2'd0) begin
            n_err++;
            $display("FAIL rs_elem3: data=%h (%0d,%0d), want c0000003 (1,0)", if_rs.out_data, if_rs.out_row, if_rs.out_col);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (if_rs.out_valid !== 1'b0 || if_rs.out_last !== 1'b0 || if_rs.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rs_flags: valid=%b last=%b in_ready=%b, want 0 0 1", if_rs.out_valid, if_rs.out_last, if_rs.in_ready);
        end
        n_vec++;
        if (if_rs.out_data !== 32'h0 || if_rs.out_row !== 2'd0 || if_rs.out_col !== 2'd0) begin
            n_err++;
            $display("FAIL rs_data: data=%h (%0d,%0d), want 0 (0,0)", if_rs.out_data, if_rs.out_row, if_rs.out_col);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if_rs.in_valid  = 1'b1;
        if_rs.in_matrix = MD;
        #1;
        n_vec++;
        if (if_rs.in_ready !== 1'b1 || if_rs.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rs_recapture: in_ready=%b valid=%b, want 1 0", if_rs.in_ready, if_rs.out_valid);
        end
        @(posedge clk);
        #1;
        if_rs.in_valid = 1'b0;
        #1;
        n_vec++;
        if (if_rs.out_valid !== 1'b1 || if_rs.out_data !== 32'hD0000000 || if_rs.out_row !== 2'd0 || if_rs.out_col !== 2'd0) begin
            n_err++;
            $display("FAIL rs_restart0: valid=%b data=%h (%0d,%0d), want 1 d0000000 (0,0)", if_rs.out_valid, if_rs.out_data,
                     if_rs.out_row, if_rs.out_col);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (if_rs.out_data !== 32'hD0000001 || if_rs.out_row !== 2'd0 || if_rs.out_col !== 2'd1) begin
            n_err++;
            $display("FAIL rs_restart1: data=%h (%0d,%0d), want d0000001 (0,1)", if_rs.out_data, if_rs.out_row, if_rs.out_col);
        end
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if (if_rs.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rs_drained: valid=%b, want 0", if_rs.out_valid);
        end
    endtask

    task automatic test_single_element();
        if_one.out_ready = 1'b1;
        if_one.in_valid  = 1'b1;
        if_one.in_matrix = 32'h7FC00000;
        #1;
        n_vec++;
        if (if_one.in_ready !== 1'b1 || if_one.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL one_capture: in_ready=%b valid=%b, want 1 0", if_one.in_ready, if_one.out_valid);
        end
        @(posedge clk);
        #1;
        // Denormal follows the NaN back-to-back through the last handshake
        if_one.in_matrix = 32'h00000001;
        #1;
        n_vec++;
        if (if_one.out_valid !== 1'b1 || if_one.out_data !== 32'h7FC00000 || if_one.out_last !== 1'b1) begin
            n_err++;
            $display("FAIL one_nan: valid=%b data=%h last=%b, want 1 7fc00000 1", if_one.out_valid, if_one.out_data, if_one.out_last);
        end
        n_vec++;
        if (if_one.in_ready !== 1'b1 || if_one.out_row !== 1'b0 || if_one.out_col !== 1'b0) begin
            n_err++;
            $display("FAIL one_ready: in_ready=%b (%0d,%0d), want 1 (0,0)", if_one.in_ready, if_one.out_row, if_one.out_col);
        end
        @(posedge clk);
        #1;
        if_one.in_valid  = 1'b0;
        if_one.in_matrix = 32'hFFFFFFFF;
        #1;
        n_vec++;
        if (if_one.out_valid !== 1'b1 || if_one.out_data !== 32'h00000001 || if_one.out_last !== 1'b1) begin
            n_err++;
            $display("FAIL one_denorm: valid=%b data=%h last=%b, want 1 00000001 1", if_one.out_valid, if_one.out_data, if_one.out_last);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (if_one.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL one_drained: valid=%b, want 0", if_one.out_valid);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        if_rm.in_valid  = 1'b0; if_rm.in_matrix  = '0; if_rm.out_ready  = 1'b0;
        if_cm.in_valid  = 1'b0; if_cm.in_matrix  = '0; if_cm.out_ready  = 1'b0;
        if_bb.in_valid  = 1'b0; if_bb.in_matrix  = '0; if_bb.out_ready  = 1'b0;
        if_rs.in_valid  = 1'b0; if_rs.in_matrix  = '0; if_rs.out_ready  = 1'b0;
        if_one.in_valid = 1'b0; if_one.in_matrix = '0; if_one.out_ready = 1'b0;
        test_reset();
        test_row_major();
        test_col_major();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_send();
        test_single_element();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
